// File: rtl/and_bist_ctrl_pkg.sv
// Shared definitions for the AND-gate BIST sequencer: state encoding and
// default parameter values.
package and_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_W      = 1;
  localparam int DEF_SETTLE = 1;
  localparam int DEF_ERR_W  = 8;

endpackage

// File: rtl/and_bist_vecgen.sv
// Exhaustive operand generator: a 2W-bit vector counter whose upper half is
// operand a and lower half is operand b.
module and_bist_vecgen
  import and_bist_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [2*W-1:0] vec,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  output logic           last
);

  localparam int VW = 2 * W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else if (clr) begin
      vec <= '0;
    end else if (inc) begin
      vec <= vec + VW'(1);
    end
  end

  assign a    = vec[2*W-1:W];
  assign b    = vec[W-1:0];
  assign last = &vec;

endmodule

// File: rtl/and_bist_ctrl.sv
// BIST sequencer for one AND unit: sweeps all operand pairs, counts mismatches.
// Optional macro AND_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module and_bist_ctrl
  import and_bist_ctrl_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     c_i,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2*W-1:0]   first_fail_vec
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state;
  logic [SW-1:0]    settle_cnt;
  logic [2*W-1:0]   vec;
  logic             vec_last;
  logic             vec_clr;
  logic             vec_inc;
  logic             mismatch;
  logic             stop;
  logic [ERR_W-1:0] err_upd;

  and_bist_vecgen #(.W(W)) u_vecgen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (vec_clr),
    .inc  (vec_inc),
    .vec  (vec),
    .a    (a_o),
    .b    (b_o),
    .last (vec_last)
  );

  always_comb begin
    mismatch = (c_i != (a_o & b_o));
    err_upd  = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_upd = err_cnt + ERR_W'(1);
    end
`ifdef AND_BIST_STOP_ON_FAIL_EN
    stop = vec_last || mismatch;
`else
    stop = vec_last;
`endif
    // Clearing on the way into DONE parks the operands at zero for IDLE.
    vec_clr = ((state == IDLE) && start) || ((state == CHECK) && stop);
    vec_inc = (state == CHECK) && !stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_cnt        <= '0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= APPLY;
          end
        end
        APPLY: begin
          settle_cnt <= '0;
          state      <= (SETTLE > 0) ? WAIT : CHECK;
        end
        WAIT: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        CHECK: begin
          err_cnt <= err_upd;
          // err_cnt saturates rather than wraps, so zero means no failure yet.
          if (mismatch && (err_cnt == '0)) begin
            first_fail_vec <= vec;
          end
          if (stop) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_upd == '0);
          end else begin
            state <= APPLY;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_bist_ctrl.sv
// Bench for and_bist_ctrl: two instances (W=1/SETTLE=1/ERR_W=8 and
// W=2/SETTLE=0/ERR_W=2) driven by injectable faulty AND models.
module tb_and_bist_ctrl;

  localparam int S1 = 1;
  localparam int S2 = 0;
`ifdef AND_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    int sel;
    int mode;
    int exp_err;
    int exp_ffv;
    int exp_pass;
    int exp_cyc;
    int poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [0:0] a1, b1, c1;
  logic       busy1, done1, pass1;
  logic [7:0] err1;
  logic [1:0] ffv1;
  logic [1:0] a2, b2, c2;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] ffv2;

  int mode = 0;
  int cur_sel = 0;
  int mask [16];
  int checks = 0;
  int failures = 0;
  int v_a, v_b, v_busy, v_done, v_pass, v_err, v_ffv;

  always #5 clk = ~clk;

  and_bist_ctrl #(.W(1), .SETTLE(S1), .ERR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .c_i(c1), .a_o(a1), .b_o(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_fail_vec(ffv1)
  );

  and_bist_ctrl #(.W(2), .SETTLE(S2), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .c_i(c2), .a_o(a2), .b_o(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_fail_vec(ffv2)
  );

  // Unit under test: 0 AND, 1 stuck-at-1, 2 OR, 3 stuck-at-0, 4 AND xor mask[vec]
  function automatic int fault_out(input int a, input int b, input int w, input int md);
    int v;
    v = (a << w) | b;
    case (md)
      1:       return (1 << w) - 1;
      2:       return a | b;
      3:       return 0;
      4:       return (a & b) ^ mask[v];
      default: return a & b;
    endcase
  endfunction

  always_comb c1 = 1'(fault_out(int'(a1), int'(b1), 1, mode));
  always_comb c2 = 2'(fault_out(int'(a2), int'(b2), 2, mode));

  always_comb begin
    if (cur_sel == 1) begin
      v_a = int'(a2); v_b = int'(b2); v_busy = int'(busy2); v_done = int'(done2);
      v_pass = int'(pass2); v_err = int'(err2); v_ffv = int'(ffv2);
    end else begin
      v_a = int'(a1); v_b = int'(b1); v_busy = int'(busy1); v_done = int'(done1);
      v_pass = int'(pass1); v_err = int'(err1); v_ffv = int'(ffv1);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: sweep every vector in order, count raw mismatches, saturate.
  function automatic void model(input int sel, input int md, output int e_err,
                                output int e_ffv, output int e_pass, output int e_cyc);
    int w, s, emax, raw, ran, a, b;
    w = (sel == 1) ? 2 : 1;
    s = (sel == 1) ? S2 : S1;
    emax = (sel == 1) ? 3 : 255;
    raw = 0;
    ran = 0;
    e_ffv = 0;
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      a = v >> w;
      b = v & ((1 << w) - 1);
      ran++;
      if (fault_out(a, b, w, md) != (a & b)) begin
        if (raw == 0) e_ffv = v;
        raw++;
        if (STOP) break;
      end
    end
    e_err = (raw > emax) ? emax : raw;
    e_pass = (raw == 0) ? 1 : 0;
    e_cyc = ran * (s + 2);
  endfunction

  task automatic run(input int sel, input int md, input int e_err, input int e_ffv,
                     input int e_pass, input int e_cyc, input int poke);
    int w, s, vec;
    w = (sel == 1) ? 2 : 1;
    s = (sel == 1) ? S2 : S1;
    cur_sel = sel;
    mode = md;
    @(negedge clk);
    check("idle_done", v_done, 0);
    check("idle_busy", v_busy, 0);
    if (sel == 1) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int m = 0; m <= e_cyc; m++) begin
      @(negedge clk);
      vec = (m < e_cyc) ? (m / (s + 2)) : 0;
      check("cyc_busy", v_busy, (m < e_cyc) ? 1 : 0);
      check("cyc_done", v_done, (m == e_cyc) ? 1 : 0);
      check("cyc_a", v_a, vec >> w);
      check("cyc_b", v_b, vec & ((1 << w) - 1));
      // start pulses while busy must be ignored
      if (poke != 0 && m < e_cyc && (m % 3) == 1) begin
        if (sel == 1) start2 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
    end
    check("res_err", v_err, e_err);
    check("res_ffv", v_ffv, e_ffv);
    check("res_pass", v_pass, e_pass);
    $display("run sel=%0d mode=%0d err=%0d ffv=%0d pass=%0d cycles=%0d",
             sel, md, v_err, v_ffv, v_pass, e_cyc);
  endtask

  initial begin
    vec_t tbl [6];
    int e_err, e_ffv, e_pass, e_cyc, sel, seen;

    foreach (mask[i]) mask[i] = 0;
`ifdef AND_BIST_STOP_ON_FAIL_EN
    tbl[0] = '{0, 0, 0, 0, 1, 12, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 3, 0};
    tbl[2] = '{0, 2, 1, 1, 0, 6, 1};
    tbl[3] = '{1, 3, 1, 5, 0, 12, 0};
    tbl[4] = '{1, 0, 0, 0, 1, 32, 1};
    tbl[5] = '{1, 1, 1, 0, 0, 2, 0};
`else
    tbl[0] = '{0, 0, 0, 0, 1, 12, 0};
    tbl[1] = '{0, 1, 3, 0, 0, 12, 0};
    tbl[2] = '{0, 2, 2, 1, 0, 12, 1};
    tbl[3] = '{1, 3, 3, 5, 0, 32, 0};
    tbl[4] = '{1, 0, 0, 0, 1, 32, 1};
    tbl[5] = '{1, 1, 3, 0, 0, 32, 0};
`endif

    #2 rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s;
      #1;
      check("rst_a", v_a, 0);
      check("rst_b", v_b, 0);
      check("rst_busy", v_busy, 0);
      check("rst_done", v_done, 0);
      check("rst_pass", v_pass, 0);
      check("rst_err", v_err, 0);
      check("rst_ffv", v_ffv, 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].sel, tbl[i].mode, tbl[i].exp_err, tbl[i].exp_ffv,
          tbl[i].exp_pass, tbl[i].exp_cyc, tbl[i].poke);
    end

    for (int r = 0; r < 8; r++) begin
      sel = int'($urandom_range(0, 1));
      foreach (mask[i]) begin
        mask[i] = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(1, (sel == 1) ? 3 : 1)) : 0;
      end
      model(sel, 4, e_err, e_ffv, e_pass, e_cyc);
      run(sel, 4, e_err, e_ffv, e_pass, e_cyc, r % 2);
    end

    // Reset in the middle of the third vector of a stuck-at-1 run.
    cur_sel = 0;
    mode = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_a", v_a, 1);
    check("mid_err", v_err, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_a", v_a, 0);
    check("mid_rst_busy", v_busy, 0);
    check("mid_rst_err", v_err, 0);
    check("mid_rst_pass", v_pass, 0);
    check("mid_rst_ffv", v_ffv, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v_done != 0 || v_busy != 0) seen = 1;
    end
    check("mid_no_done", seen, 0);
    $display("run sel=0 mode=1 reset mid-run, activity_after_reset=%0d", seen);

    run(0, 0, 0, 0, 1, 12, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
